// File: rtl/bridge_bus_arbiter.sv
// bridge_bus_arbiter: two-master round-robin arbiter for the bridge device bus with slave timeout (optional lock: BUS_LOCK_EN)
module bridge_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
`ifdef BUS_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          s_valid,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_we,
    input  logic          s_ready,
    input  logic [DW-1:0] s_rdata
);
    typedef enum logic [1:0] {IDLE, BUS0, BUS1} state_t;
    state_t state;
    logic last_gnt;
    logic [7:0] timer;
    logic el0, el1, win, cur, sel, keep, timed_out;
    // a master that is still seeing its done pulse sits out one arbitration round
    assign el0 = m0_req & ~m0_done;
    assign el1 = m1_req & ~m1_done;
    assign win = (el0 & el1) ? ~last_gnt : el1;
    assign cur = state == BUS1;
    assign sel = (state == IDLE) ? win : cur;
    assign m0_gnt = state == BUS0;
    assign m1_gnt = state == BUS1;
    assign timed_out = timer == 8'(TIMEOUT - 1);
`ifdef BUS_LOCK_EN
    assign keep = cur ? (m1_lock & m1_req) : (m0_lock & m0_req);
`else
    assign keep = 1'b0;
`endif
    // arbitration, bus ownership, completion and timeout handling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            timer    <= '0;
            s_valid  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_we     <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
            if (state == IDLE) begin
                if (el0 | el1) begin
                    state    <= win ? BUS1 : BUS0;
                    last_gnt <= win;
                    timer    <= '0;
                    s_valid  <= 1'b1;
                    s_addr   <= sel ? m1_addr : m0_addr;
                    s_wdata  <= sel ? m1_wdata : m0_wdata;
                    s_we     <= sel ? m1_we : m0_we;
                end
            end else if (s_ready) begin
                if (cur) begin
                    m1_done <= 1'b1;
                    if (!s_we) m1_rdata <= s_rdata;
                end else begin
                    m0_done <= 1'b1;
                    if (!s_we) m0_rdata <= s_rdata;
                end
                if (keep) begin
                    timer   <= '0;
                    s_addr  <= sel ? m1_addr : m0_addr;
                    s_wdata <= sel ? m1_wdata : m0_wdata;
                    s_we    <= sel ? m1_we : m0_we;
                end else begin
                    state   <= IDLE;
                    s_valid <= 1'b0;
                end
            end else if (timed_out) begin
                state   <= IDLE;
                s_valid <= 1'b0;
                if (cur) begin
                    m1_done  <= 1'b1;
                    m1_err   <= 1'b1;
                    m1_rdata <= '0;
                end else begin
                    m0_done  <= 1'b1;
                    m0_err   <= 1'b1;
                    m0_rdata <= '0;
                end
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// tb_bridge_bus_arbiter: directed scoreboard bench for bridge_bus_arbiter (lock steps only with BUS_LOCK_EN)
module tb_bridge_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic s_valid, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
`ifdef BUS_LOCK_EN
    logic m0_lock, m1_lock;
`endif
    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] rdata;
    } sb_t;
    sb_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int n;

    bridge_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
`ifdef BUS_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic err, input logic [31:0] rdata);
        sb_t e;
        e.m = m;
        e.err = err;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        sb_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_done"}, {31'd0, e.m ? m1_done : m0_done}, 32'd1);
            chk({tag, "_other_done"}, {31'd0, e.m ? m0_done : m1_done}, 32'd0);
            chk({tag, "_err"}, {31'd0, e.m ? m1_err : m0_err}, {31'd0, e.err});
            chk({tag, "_rdata"}, e.m ? m1_rdata : m0_rdata, e.rdata);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_valid"}, {31'd0, s_valid}, 32'd0);
        chk({tag, "_s_addr"}, s_addr, 32'd0);
        chk({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk({tag, "_done"}, {30'd0, m1_done, m0_done}, 32'd0);
        chk({tag, "_err"}, {30'd0, m1_err, m0_err}, 32'd0);
        chk({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
`ifdef BUS_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
        tick();
        tick();
        chk_zero("reset");
        // single read from m0
        reset = 1'b1;
        m0_req = 1; m0_addr = 32'h7F00; m0_we = 0;
        tick();
        chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h7F00);
        s_ready = 1; s_rdata = 32'h1234ABCD;
        push(0, 0, 32'h1234ABCD);
        tick();
        sb_check("t1");
        chk("t1_s_valid_drop", {31'd0, s_valid}, 32'd0);
        m0_req = 0; s_ready = 0;
        tick();
        chk("t1_done_pulse", {31'd0, m0_done}, 32'd0);
        // simultaneous requests alternate after a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m0_req = 1; m0_addr = 32'h100; m0_we = 0;
        m1_req = 1; m1_addr = 32'h200; m1_we = 0;
        s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, (i % 2) ? 32'd2 : 32'd1);
            chk($sformatf("t2_addr%0d", i), s_addr, (i % 2) ? 32'h200 : 32'h100);
            chk($sformatf("t2_prev_done%0d", i), {30'd0, m1_done, m0_done}, 32'd0);
            s_rdata = 32'hA000_0000 + 32'(i);
            push((i % 2) != 0, 0, 32'hA000_0000 + 32'(i));
            tick();
            sb_check($sformatf("t2_x%0d", i));
            chk($sformatf("t2_addr_hold%0d", i), s_addr, (i % 2) ? 32'h200 : 32'h100);
        end
        m0_req = 0; m1_req = 0; s_ready = 0;
        tick();
        // m1 write with no ready: timeout
        m1_req = 1; m1_addr = 32'h7F10; m1_wdata = 32'hDEADBEEF; m1_we = 1;
        tick();
        chk("t3_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        chk("t3_s_we", {31'd0, s_we}, 32'd1);
        chk("t3_s_wdata", s_wdata, 32'hDEADBEEF);
        chk("t3_s_addr", s_addr, 32'h7F10);
        push(1, 1, 32'd0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (m1_done) break;
        end
        chk("t3_cycles", 32'(n), 32'd15);
        sb_check("t3");
        chk("t3_s_valid", {31'd0, s_valid}, 32'd0);
        m1_req = 0; m1_we = 0;
        tick();
        // delayed ready with address change and request drop mid-transaction
        m0_req = 1; m0_addr = 32'h7F20; m0_we = 0;
        tick();
        chk("t4_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m0_addr = 32'h1111; m0_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_addr_hold%0d", i), s_addr, 32'h7F20);
            chk($sformatf("t4_valid%0d", i), {31'd0, s_valid}, 32'd1);
        end
        s_ready = 1; s_rdata = 32'hCAFEF00D;
        push(0, 0, 32'hCAFEF00D);
        tick();
        sb_check("t4");
        s_ready = 0;
        tick();
        // asynchronous reset in the middle of a BUS1 transaction
        m1_req = 1; m1_addr = 32'h7F30; m1_we = 0;
        tick();
        chk("t5_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("t5_async");
        s_ready = 1;
        tick();
        tick();
        chk("t5_no_done", {30'd0, m1_done, m0_done}, 32'd0);
        s_ready = 0;
        reset = 1'b1;
        m0_req = 1; m0_addr = 32'h7F40; m0_we = 0;
        tick();
        chk("t5_tie_m0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        s_ready = 1; s_rdata = 32'h5555AAAA;
        push(0, 0, 32'h5555AAAA);
        tick();
        sb_check("t5_m0");
        m0_req = 0; s_rdata = 32'h66667777;
        push(1, 0, 32'h66667777);
        tick();
        chk("t5_gnt_m1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        chk("t5_s_addr", s_addr, 32'h7F30);
        tick();
        sb_check("t5_m1");
        m1_req = 0; s_ready = 0;
        tick();
`ifdef BUS_LOCK_EN
        // locked back-to-back writes from m0 while m1 waits
        m0_req = 1; m0_lock = 1; m0_we = 1; m0_addr = 32'h7F50; m0_wdata = 32'd1;
        tick();
        chk("t6_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m1_req = 1; s_ready = 1;
        for (int i = 1; i <= 2; i++) begin
            m0_addr = 32'h7F50 + 32'(i); m0_wdata = 32'(i + 1);
            push(0, 0, 32'h5555AAAA);
            tick();
            sb_check($sformatf("t6_x%0d", i));
            chk($sformatf("t6_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd1);
            chk($sformatf("t6_addr%0d", i), s_addr, 32'h7F50 + 32'(i));
            chk($sformatf("t6_valid%0d", i), {31'd0, s_valid}, 32'd1);
        end
        m0_lock = 0;
        push(0, 0, 32'h5555AAAA);
        tick();
        sb_check("t6_x3");
        chk("t6_release", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        m0_req = 0; m0_we = 0; s_rdata = 32'h77778888;
        push(1, 0, 32'h77778888);
        tick();
        chk("t6_gnt_m1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        tick();
        sb_check("t6_m1");
        m1_req = 0; s_ready = 0;
        tick();
`endif
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bridge_bus_arbiter.md
Name: bridge_bus_arbiter

Overview:
Shares the single bridge-side device bus between two masters. Master 0 is the CPU data port (PrAddr/PrWD/PrWe path). Master 1 is the DMA/debug loader.
- Latches the winning master's request, drives it onto the device bus and waits for the slave's ready.
- Returns read data plus a one-cycle done pulse, or an error pulse on slave timeout.
- Sits between mips and the bridge; m0_gnt/m0_done are used to stall the CPU M stage.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles in a bus state without s_ready before error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
m0_req  input  1  CPU request; held until m0_done
m0_addr  input  AW  CPU address
m0_wdata  input  DW  CPU write data
m0_we  input  1  CPU write enable (1 = write, 0 = read)
m0_gnt  output  1  CPU currently owns bus
m0_done  output  1  one-cycle completion pulse to CPU
m0_err  output  1  qualifies m0_done: timeout
m0_rdata  output  DW  read data to CPU, valid with m0_done
m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_done, m1_err, m1_rdata: same as m0_* for master 1
s_valid  output  1  bus transaction active
s_addr  output  AW  bus address
s_wdata  output  DW  bus write data
s_we  output  1  bus write enable
s_ready  input  1  slave accepts/completes in this cycle
s_rdata  input  DW  slave read data, sampled when s_ready=1

Behaviour:
- Reset values:
  - state IDLE, last_gnt=1 (so m0 wins the first tie), timer=0.
  - All outputs 0.
- States: IDLE, BUS0, BUS1.
- IDLE arbitration, sampled at the clock edge:
  - eligible_x = mx_req & ~mx_done.
  - Both eligible: grant the master != last_gnt.
  - One eligible: grant it.
  - None: stay in IDLE.
- Grant edge:
  - Register s_addr/s_wdata/s_we from the winner; set s_valid=1.
  - last_gnt <= winner; timer <= 0.
- mx_gnt = (state == BUSx); decoded from state, no extra latency.
- BUSx with s_ready=1:
  - Next cycle: state IDLE, s_valid=0, mx_done=1, mx_err=0.
  - mx_rdata <= s_rdata on reads; unchanged on writes.
- BUSx with s_ready=0:
  - Timer increments each cycle.
  - When timer == TIMEOUT-1 at the edge: state IDLE, mx_done=1, mx_err=1, mx_rdata=0.
- Latency:
  - req high before edge k -> s_valid from cycle k+1.
  - s_ready in cycle k+1 -> done high in cycle k+2.
  - Minimum 2 cycles req-to-done.
  - Back-to-back same master: at least 1 IDLE cycle between transactions.
- mx_done and mx_err are single-cycle pulses.
- s_* outputs are stable for the whole bus state, and change only on the grant edge or the exit edge.
- mx_req dropped mid-transaction: the transaction still completes and done still pulses.
- Request changes after grant are ignored; the latched copy is used.
- A request asserted in the same cycle as another master's done: arbitrated normally in the following IDLE cycle.
- s_ready outside a bus state is ignored.
- Reset asserted mid-transaction: immediate return to reset values; no done pulse.
- TIMEOUT=1: error on the first cycle without ready.

Optional Feature:
BUS_LOCK_EN
- Defined:
  - Adds inputs m0_lock and m1_lock.
  - Completion with mx_lock=1 and mx_req=1: the arbiter goes directly BUSx -> BUSx.
  - Latches new request fields and restarts the timer. done still pulses for the finished transaction.
  - last_gnt is not updated, so lock preserves ownership; back-to-back latency is 1 cycle.
  - A timeout error always releases the lock (return to IDLE).
- Not defined: lock ports are absent; the arbiter always returns to IDLE after every transaction.

Test Plan:
1. Reset release, m0 read addr 0x7F00, slave ready next cycle with rdata 0x1234ABCD -> s_valid in cycle 1, m0_done=1 and m0_rdata=0x1234ABCD in cycle 2, m0_err=0.
2. m0 and m1 request in the same cycle, both repeat -> grants m0, m1, m0, m1; each done pulse is exactly 1 cycle; s_addr switches only on grant edges.
3. m1 write 0x7F10 data 0xDEADBEEF, slave ready held 0 -> m1_done=1 and m1_err=1 exactly TIMEOUT=15 cycles after grant; s_valid drops; m1_rdata=0.
4. m0 transaction in progress, slave ready delayed 3 cycles, m0_addr changed during wait -> s_addr keeps the original value; done after ready.
5. reset driven low mid-BUS1 -> all outputs 0 asynchronously; no done pulse; after release the first tie is granted to m0.
6. BUS_LOCK_EN: m0 lock=1 issuing 3 writes while m1 requests -> m0 keeps the bus for all 3 with 1-cycle spacing; m1 is granted in the cycle after lock drops.
